// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters.
// Launches the master with newd/din, tracks its cs and returns per-requester ack/err pulses.
module spi_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 63,
    parameter int GAP_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    output logic                      spi_newd,
    output logic [DATA_W-1:0]         spi_din,
    input  logic                      spi_cs
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  w_grant_next;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_next;
    logic [NUM_REQ-1:0]  r_err;
    logic [NUM_REQ-1:0]  w_err_next;
    logic                r_newd;
    logic                w_newd_next;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   w_din_next;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       w_timer_next;
    logic [GW-1:0]       r_gap;
    logic [GW-1:0]       w_gap_next;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr_next;
    logic [PW-1:0]       r_owner;
    logic [PW-1:0]       w_owner_next;

    logic                r_cs_meta;
    logic                r_cs_s;

    logic [DATA_W-1:0]   w_slot [NUM_REQ];
    logic                w_win_found;
    logic [PW-1:0]       w_win_idx;
    logic [NUM_REQ-1:0]  w_win_onehot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign w_slot[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // cs comes from the sclk domain; both flops preset high so an idle master is assumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_meta <= 1'b1;
            r_cs_s    <= 1'b1;
        end else begin
            r_cs_meta <= spi_cs;
            r_cs_s    <= r_cs_meta;
        end
    end

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        int idx;
        idx         = 0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_win_found && req[idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = PW'(idx);
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << w_win_idx;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_ack_next   = '0;
        w_err_next   = '0;
        w_newd_next  = r_newd;
        w_din_next   = r_din;
        w_timer_next = r_timer;
        w_gap_next   = r_gap;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_win_found && r_cs_s) begin
                    w_grant_next = w_win_onehot;
                    w_din_next   = w_slot[w_win_idx];
                    w_newd_next  = 1'b1;
                    w_timer_next = '0;
                    w_owner_next = w_win_idx;
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_timer_next = r_timer + TW'(1);
                // A cs fall seen on the timeout cycle still counts as a started transfer.
                if (!r_cs_s) begin
                    w_newd_next  = 1'b0;
                    w_state_next = S_BUSY;
                end else if (r_timer == TW'(TIMEOUT)) begin
                    w_newd_next  = 1'b0;
                    w_err_next   = r_grant;
                    w_grant_next = '0;
                    w_ptr_next   = r_owner;
                    w_gap_next   = '0;
                    w_state_next = S_GAP;
                end
            end
            S_BUSY: begin
                if (r_cs_s) begin
                    w_ack_next   = r_grant;
                    w_grant_next = '0;
                    w_ptr_next   = r_owner;
                    w_gap_next   = '0;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GW'(GAP_CYC - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap + GW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_newd  <= 1'b0;
            r_din   <= '0;
            r_timer <= '0;
            r_gap   <= '0;
            r_ptr   <= PW'(NUM_REQ - 1);
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_ack   <= w_ack_next;
            r_err   <= w_err_next;
            r_newd  <= w_newd_next;
            r_din   <= w_din_next;
            r_timer <= w_timer_next;
            r_gap   <= w_gap_next;
            r_ptr   <= w_ptr_next;
            r_owner <= w_owner_next;
        end
    end

    assign grant    = r_grant;
    assign ack      = r_ack;
    assign err      = r_err;
    assign busy     = (r_state != S_IDLE);
    assign spi_newd = r_newd;
    assign spi_din  = r_din;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: directed scenarios plus random request masks, checked
// against a round-robin pick model and a simple SPI master stand-in.
module tb_spi_req_arbiter;

    localparam int N   = 4;
    localparam int DW  = 12;
    localparam int TO  = 63;
    localparam int GC  = 2;
    localparam int RDW = N * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [RDW-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic [N-1:0]   err;
    logic           busy;
    logic           spi_newd;
    logic [DW-1:0]  spi_din;
    logic           spi_cs;

    spi_req_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .GAP_CYC (GC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .spi_newd (spi_newd),
        .spi_din  (spi_din),
        .spi_cs   (spi_cs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int m_last   = N - 1;

    bit            master_en = 1'b1;
    logic [DW-1:0] m_word = '0;
    int            rise_cyc = 0;

    // SPI master stand-in: takes din on newd, holds cs low for a random length, then releases.
    initial begin
        bit m_active;
        int m_len;
        int m_cnt;
        m_active = 1'b0;
        m_len    = 0;
        m_cnt    = 0;
        spi_cs   = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                spi_cs   = 1'b1;
                m_active = 1'b0;
            end else if (m_active) begin
                m_cnt++;
                if (m_cnt >= m_len) begin
                    spi_cs   = 1'b1;
                    m_active = 1'b0;
                    rise_cyc = cyc;
                end
            end else if (spi_newd && master_en) begin
                m_word   = spi_din;
                m_len    = $urandom_range(8, 20);
                m_cnt    = 0;
                spi_cs   = 1'b0;
                m_active = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_ack",   64'(ack),   64'(0));
        check("rst_err",   64'(err),   64'(0));
        check("rst_busy",  64'(busy),  64'(0));
        check("rst_newd",  64'(spi_newd), 64'(0));
        check("rst_din",   64'(spi_din),  64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        m_last = N - 1;
    endtask

    task automatic run_transfer(input bit exp_timeout, input logic [N-1:0] drop, output int launch_wait);
        int            exp;
        int            w;
        int            newd_cnt;
        bit            got;
        bit            stable;
        bit            dropped;
        logic [DW-1:0] exp_data;
        logic [N-1:0]  exp_onehot;
        launch_wait = 0;
        exp = rr_pick(req, m_last);
        if (exp < 0) return;
        exp_onehot = N'(1) << exp;
        exp_data   = req_data[exp*DW +: DW];
        w = 0;
        got = 1'b0;
        while (w < 40 && !got) begin
            @(negedge clk);
            w++;
            got = (grant != '0);
        end
        launch_wait = w;
        check("grant_seen", 64'(got), 64'(1));
        if (!got) return;
        check("grant",        64'(grant),    64'(exp_onehot));
        check("din",          64'(spi_din),  64'(exp_data));
        check("newd_launch",  64'(spi_newd), 64'(1));
        check("busy_launch",  64'(busy),     64'(1));
        req_data = RDW'({$urandom(), $urandom()});
        newd_cnt = 1;
        stable   = 1'b1;
        dropped  = 1'b0;
        got      = 1'b0;
        w        = 0;
        while (w < 300 && !got) begin
            @(negedge clk);
            w++;
            if (ack != '0 || err != '0) begin
                got = 1'b1;
            end else begin
                if (spi_newd) newd_cnt++;
                if (grant !== exp_onehot || spi_din !== exp_data) stable = 1'b0;
                if (!spi_newd && !dropped && drop != '0) begin
                    req     = req & ~drop;
                    dropped = 1'b1;
                end
            end
        end
        check("result_seen", 64'(got), 64'(1));
        if (!got) return;
        check("held_stable", 64'(stable), 64'(1));
        check("ack", 64'(ack), exp_timeout ? 64'(0) : 64'(exp_onehot));
        check("err", 64'(err), exp_timeout ? 64'(exp_onehot) : 64'(0));
        check("grant_clear", 64'(grant), 64'(0));
        if (exp_timeout) begin
            check("newd_len", 64'(newd_cnt), 64'(TO + 1));
        end else begin
            check("mosi_word",   64'(m_word),         64'(exp_data));
            check("ack_latency", 64'(cyc - rise_cyc), 64'(3));
        end
        $display("xfer: req=%b owner=%0d data=%h %s", req, exp, exp_data, exp_timeout ? "err" : "ack");
        @(negedge clk);
        check("pulse_1clk", 64'({ack, err}), 64'(0));
        check("busy_gap",   64'(busy),       64'(1));
        m_last = exp;
    endtask

    initial begin
        int  lw;
        int  w;
        bit  got;

        // 1: single requester, fixed word, launch latency
        do_reset();
        req_data        = RDW'({$urandom(), $urandom()});
        req_data[11:0]  = 12'hA5C;
        req             = 4'b0001;
        run_transfer(1'b0, '0, lw);
        check("launch_latency", 64'(lw), 64'(1));

        // 2: two requesters alternate
        do_reset();
        req_data = RDW'({$urandom(), $urandom()});
        req      = 4'b0011;
        repeat (4) run_transfer(1'b0, '0, lw);

        // 3: all four requesters, two full rounds
        do_reset();
        req_data = RDW'({$urandom(), $urandom()});
        req      = 4'b1111;
        repeat (8) run_transfer(1'b0, '0, lw);

        // 4: master never starts -> err, then arbitration resumes after requester 2
        req       = 4'b0100;
        master_en = 1'b0;
        run_transfer(1'b1, '0, lw);
        master_en = 1'b1;
        req       = 4'b1111;
        run_transfer(1'b0, '0, lw);

        // 5: reset while BUSY
        do_reset();
        req_data        = RDW'({$urandom(), $urandom()});
        req_data[23:12] = 12'h3C1;
        req             = 4'b0010;
        w   = 0;
        got = 1'b0;
        while (w < 40 && !got) begin
            @(negedge clk);
            w++;
            got = (grant != '0) && !spi_newd;
        end
        check("busy_reached", 64'(got), 64'(1));
        @(negedge clk);
        check("pre_rst_grant", 64'(grant), 64'(4'b0010));
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        m_last = N - 1;
        run_transfer(1'b0, '0, lw);

        // 6: owner drops req mid-BUSY
        do_reset();
        req_data = RDW'({$urandom(), $urandom()});
        req      = 4'b1110;
        run_transfer(1'b0, 4'b0010, lw);
        repeat (3) run_transfer(1'b0, '0, lw);

        // random masks with occasional absent master
        for (int i = 0; i < 16; i++) begin
            req       = N'($urandom_range(1, (1 << N) - 1));
            req_data  = RDW'({$urandom(), $urandom()});
            master_en = ($urandom_range(0, 5) != 0);
            run_transfer(!master_en, '0, lw);
        end
        master_en = 1'b1;
        req       = '0;
        repeat (4) @(negedge clk);
        check("final_busy",  64'(busy),     64'(0));
        check("final_grant", 64'(grant),    64'(0));
        check("final_newd",  64'(spi_newd), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
